approx_mult_pipe: RTL and testbench

Parametrised, two-stage pipelined unsigned N×N multiplier with per-transaction selection between exact and approximate products. In approximate mode the L least-significant multiplier rows are OR-compressed above a cut-off column instead of added, trading accuracy for adder area. It extends the fixed 8×8 combinational approximate multipliers to:

- configurable width and approximation level;
- valid/ready streaming with backpressure;
- a run-time exact/approximate mode;
- a usage counter.

It sits in the datapath between an operand source and an accumulator or sink.

---
 rtl/approx_mult_pipe_if.sv | 25 ++
 rtl/approx_mult_pipe.sv | 112 +++++++++++
 tb/tb_approx_mult_pipe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pipe_if.sv
// Streaming operand/result bundle for approx_mult_pipe.
// The slave modport is the multiplier; the master modport is the source plus sink side.
interface approx_mult_pipe_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           in_exact;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] z;
  logic           out_exact;

  modport master (
    output in_valid, x, y, in_exact, out_ready,
    input  in_ready, out_valid, z, out_exact
  );

  modport slave (
    input  in_valid, x, y, in_exact, out_ready,
    output in_ready, out_valid, z, out_exact
  );
endinterface

// File: rtl/approx_mult_pipe.sv
// Two-stage unsigned NxN multiplier with per-transaction exact/approximate mode.
// Approximate mode OR-compresses the L low multiplier rows from column K upward.
module approx_mult_pipe #(
  parameter int N  = 8,
  parameter int L  = 2,
  parameter int K  = N - 1,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  approx_mult_pipe_if.slave   bus,
  output logic [CW-1:0]       approx_count
);

  localparam int W = 2 * N;
  localparam logic [W-1:0]  LOW_MASK = W'((1 << L) - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [W-1:0] x_ext;
  logic [W-1:0] y_ext;
  logic [W-1:0] h_part;
  logic [W-1:0] low_part;
  logic [W-1:0] c_part;

  logic         s1_valid;
  logic         s1_exact;
  logic [W-1:0] s1_h;
  logic [W-1:0] s1_c;
  logic [W-1:0] s1_low;

  logic         out_valid_q;
  logic         out_exact_q;
  logic [W-1:0] z_q;

  logic         adv1;
  logic         adv2;

  assign x_ext = {{N{1'b0}}, bus.x};
  assign y_ext = {{N{1'b0}}, bus.y};

  // Masking instead of slicing x keeps the L = 0 build legal.
  assign h_part   = y_ext * (x_ext & ~LOW_MASK);
  assign low_part = y_ext * (x_ext & LOW_MASK);

  // One OR-reduced bit per kept column; columns outside K..N+L-2 are discarded.
  for (genvar k = 0; k < W; k++) begin : g_col
    if (k >= K && k <= N + L - 2) begin : g_kept
      logic [L:0] acc;
      assign acc[0] = 1'b0;
      for (genvar i = 0; i < L; i++) begin : g_row
        if (k - i >= 0 && k - i <= N - 1) begin : g_hit
          assign acc[i+1] = acc[i] | (bus.x[i] & bus.y[k-i]);
        end else begin : g_miss
          assign acc[i+1] = acc[i];
        end
      end
      assign c_part[k] = acc[L];
    end else begin : g_drop
      assign c_part[k] = 1'b0;
    end
  end

  assign adv2 = !out_valid_q || bus.out_ready;
  assign adv1 = !s1_valid || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.out_exact = out_exact_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_exact <= 1'b0;
      s1_h     <= '0;
      s1_c     <= '0;
      s1_low   <= '0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_exact <= bus.in_exact;
        s1_h     <= h_part;
        s1_c     <= c_part;
        s1_low   <= low_part;
      end
    end
  end

  // z and out_exact only reload with a real transaction, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_exact_q <= 1'b0;
      z_q         <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_exact_q <= s1_exact;
        z_q         <= s1_exact ? (s1_h + s1_low) : (s1_h + s1_c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      approx_count <= '0;
    end else if (out_valid_q && bus.out_ready && !out_exact_q && approx_count != CNT_MAX) begin
      approx_count <= approx_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: directed table, backpressure, random stream with scoreboard,
// reset mid-flight, and a CW=4 / L=0 instance for saturation and the degenerate build.
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] approx_count;
  logic [3:0]  approx_count2;

  approx_mult_pipe_if #(.N(8)) bus ();
  approx_mult_pipe_if #(.N(8)) bus2 ();

  approx_mult_pipe #(.N(8), .L(2), .K(7), .CW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .approx_count(approx_count)
  );

  approx_mult_pipe #(.N(8), .L(0), .K(7), .CW(4)) dut_l0 (
    .clk(clk), .rst(rst), .bus(bus2), .approx_count(approx_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ex;
    logic [15:0] z;
  } vec_t;

  typedef struct {
    logic [15:0] z;
    logic        ex;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vecs[10];
  int          checks = 0;
  int          failures = 0;
  int          model_count = 0;
  int          deliveries = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_z = '0;
  logic        prev_ex = 1'b0;

  // Product straight from the column definition, for an 8-bit operand build.
  function automatic logic [15:0] ref_mult(input int xv, input int yv, input bit ex,
                                           input int l, input int k);
    int h, c, col;
    if (ex) return 16'(xv * yv);
    h = ((xv >> l) * yv) << l;
    c = 0;
    for (int kk = k; kk <= 8 + l - 2; kk++) begin
      col = 0;
      for (int i = 0; i < l; i++)
        if (kk - i >= 0 && kk - i <= 7)
          col = col | (((xv >> i) & 1) & ((yv >> (kk - i)) & 1));
      if (col != 0) c = c + (1 << kk);
    end
    return 16'(h + c);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // One clock of the main DUT: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input logic iv, input logic [7:0] xx, input logic [7:0] yy,
                      input logic ex, input logic ordy,
                      output logic acc, output logic dlv,
                      output logic [15:0] zs, output logic exs);
    exp_t e;
    bus.in_valid  = iv;
    bus.x         = xx;
    bus.y         = yy;
    bus.in_exact  = ex;
    bus.out_ready = ordy;
    @(negedge clk);
    checkOutput("approx_count", approx_count, model_count);
    checkOutput("in_ready", bus.in_ready, (exp_q.size() < 2) || ordy);
    if (prev_stall) begin
      checkOutput("stall_out_valid", bus.out_valid, 1);
      checkOutput("stall_z", bus.z, prev_z);
      checkOutput("stall_out_exact", bus.out_exact, prev_ex);
    end
    acc = iv && bus.in_ready;
    dlv = bus.out_valid && ordy;
    zs  = bus.z;
    exs = bus.out_exact;
    if (dlv) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("z", bus.z, e.z);
        checkOutput("out_exact", bus.out_exact, e.ex);
        if (!e.ex && model_count < 65535) model_count++;
        deliveries++;
      end
    end
    if (acc) exp_q.push_back('{ref_mult(xx, yy, ex, 2, 7), ex});
    prev_stall = bus.out_valid && !ordy;
    prev_z     = bus.z;
    prev_ex    = bus.out_exact;
    @(posedge clk);
    #1;
  endtask

  // Single transaction with the sink always ready; checks value, mode and latency.
  task automatic applyStimulus(input vec_t v);
    logic acc, dlv, exs;
    logic [15:0] zs, zd;
    logic exd;
    int acc_at, dlv_at;
    acc_at = -1;
    dlv_at = -1;
    zd = '0;
    exd = 1'b0;
    for (int c = 0; c < 12 && dlv_at < 0; c++) begin
      step(acc_at < 0, v.x, v.y, v.ex, 1'b1, acc, dlv, zs, exs);
      if (acc && acc_at < 0) acc_at = c;
      if (dlv) begin
        dlv_at = c;
        zd = zs;
        exd = exs;
      end
    end
    if (dlv_at < 0) begin
      timeoutFail("vector_delivery");
    end else begin
      checkOutput($sformatf("vec_z x=%0d y=%0d ex=%0d", v.x, v.y, v.ex), zd, v.z);
      checkOutput("vec_out_exact", exd, v.ex);
      checkOutput("vec_latency", dlv_at - acc_at, 2);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc, dlv, exs;
    logic [15:0] zs;
    logic [7:0] bx[6];
    logic [7:0] by[6];
    logic [7:0] rx, ry;
    int idx, d0, acc2, dl2;

    vecs[0] = '{8'd255, 8'd255, 1'b1, 16'd65025};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 16'd64644};
    vecs[2] = '{8'd3,   8'd200, 1'b0, 16'd384};
    vecs[3] = '{8'd3,   8'd200, 1'b1, 16'd600};
    vecs[4] = '{8'd4,   8'd10,  1'b0, 16'd40};
    vecs[5] = '{8'd4,   8'd10,  1'b1, 16'd40};
    vecs[6] = '{8'd1,   8'd255, 1'b0, 16'd128};
    vecs[7] = '{8'd2,   8'd128, 1'b0, 16'd256};
    vecs[8] = '{8'd255, 8'd0,   1'b0, 16'd0};
    vecs[9] = '{8'd0,   8'd255, 1'b0, 16'd0};

    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.in_exact = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.x = '0; bus2.y = '0; bus2.in_exact = 1'b0; bus2.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_z", bus.z, 0);
    checkOutput("reset_out_exact", bus.out_exact, 0);
    checkOutput("reset_approx_count", approx_count, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      if (i == 2) checkOutput("approx_count_after_two", approx_count, 2);
    end

    // Backpressure: sink stalled for the first four cycles, modes alternating.
    for (int i = 0; i < 6; i++) begin
      bx[i] = 8'($urandom);
      by[i] = 8'($urandom);
    end
    idx = 0;
    d0 = deliveries;
    for (int cyc = 0; cyc < 30 && deliveries - d0 < 5; cyc++) begin
      step(idx < 5, bx[idx], by[idx], (idx % 2) == 1, cyc >= 4, acc, dlv, zs, exs);
      if (acc) idx++;
      if (cyc == 3) checkOutput("bp_accepted_while_stalled", idx, 2);
    end
    checkOutput("bp_delivered", deliveries - d0, 5);
    checkOutput("bp_queue_empty", exp_q.size(), 0);

    for (int cyc = 0; cyc < 2500; cyc++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      case ($urandom_range(0, 7))
        0: rx = 8'h00;
        1: rx = 8'hFF;
        2: ry = 8'hFF;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, rx, ry, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7, acc, dlv, zs, exs);
    end
    for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++)
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, dlv, zs, exs);
    checkOutput("random_drain_empty", exp_q.size(), 0);

    // Reset with both stages full; rst must win over a simultaneous accept and delivery.
    step(1'b1, 8'd200, 8'd77, 1'b0, 1'b0, acc, dlv, zs, exs);
    step(1'b1, 8'd99, 8'd181, 1'b1, 1'b0, acc, dlv, zs, exs);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput("midreset_out_valid", bus.out_valid, 0);
    checkOutput("midreset_z", bus.z, 0);
    checkOutput("midreset_out_exact", bus.out_exact, 0);
    checkOutput("midreset_approx_count", approx_count, 0);
    checkOutput("midreset_in_ready", bus.in_ready, 1);
    exp_q.delete();
    model_count = 0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++)
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, dlv, zs, exs);
    checkOutput("midreset_no_stale", exp_q.size(), 0);

    // L=0, CW=4 instance: approximate equals exact, counter saturates at 15.
    acc2 = 0;
    dl2 = 0;
    bus2.out_ready = 1'b1;
    bus2.in_exact  = 1'b0;
    bus2.x = 8'd255;
    bus2.y = 8'd255;
    for (int cyc = 0; cyc < 80 && dl2 < 20; cyc++) begin
      bus2.in_valid = acc2 < 20;
      @(negedge clk);
      if (bus2.out_valid) begin
        dl2++;
        checkOutput("l0_z", bus2.z, 65025);
        checkOutput("l0_out_exact", bus2.out_exact, 0);
      end
      if (bus2.in_valid && bus2.in_ready) acc2++;
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    if (dl2 < 20) timeoutFail("l0_deliveries");
    checkOutput("saturated_approx_count", approx_count2, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
